// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back FIFO draining ALU/load results into the regfile write port
// Define WB_FWD_EN to build the forwarding search; otherwise fwd_hit/fwd_data are tied to 0.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [ADDR_W-1:0]         mem_rd,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      mem_ready,
    input  logic                      wb_stall,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic [$clog2(DEPTH):0]    count,
    input  logic [ADDR_W-1:0]         fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     free;
    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              mem_push, alu_push, pop;
    logic [AW-1:0]     alu_slot;

    // Readiness looks only at registered occupancy, so a same-edge pop never frees a slot early.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        mem_ready = (free != '0);
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);
        mem_push  = mem_valid && mem_ready && (mem_rd != '0);
        alu_push  = alu_valid && alu_ready && (alu_rd != '0);
        pop       = (count_q != '0) && !wb_stall;
    end

    always_comb begin
        rd_mem_d     = rd_mem_q;
        data_mem_d   = data_mem_q;
        alu_slot     = wr_ptr_q + AW'(mem_push);
        wr_ptr_d     = wr_ptr_q + AW'(mem_push) + AW'(alu_push);
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        reg_write_d  = pop;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (mem_push) begin
            rd_mem_d[wr_ptr_q]   = mem_rd;
            data_mem_d[wr_ptr_q] = mem_data;
        end
        // A same-edge load result is older, so the ALU entry lands one slot behind it.
        if (alu_push) begin
            rd_mem_d[alu_slot]   = alu_rd;
            data_mem_d[alu_slot] = alu_data;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            write_reg_d  = rd_mem_q[rd_ptr_q];
            write_data_d = data_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge clock) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign count     = count_q;

`ifdef WB_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match seen is the newest pending value.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_addr != '0) begin
            if (reg_write_q && (write_reg_q == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = write_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr_q + AW'(i);
                if ((CW'(i) < count_q) && (rd_mem_q[fwd_idx] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem_q[fwd_idx];
                end
            end
        end
    end
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed bench for wb_queue against a queue-based behavioural model
module tb_wb_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CW     = 3;

    logic              clock;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              wb_stall;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .count(count),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    logic              m_rw;
    logic [ADDR_W-1:0] m_wreg;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] seen[$];
    logic              acc_m, acc_a;
    ent_t              e_tmp;
    logic              f_hit;
    logic [DATA_W-1:0] f_data;

    function automatic logic exp_mem_ready();
        return (DEPTH - mq.size()) >= 1;
    endfunction

    function automatic logic exp_alu_ready();
        int fr;
        fr = DEPTH - mq.size();
        return (fr >= 2) || (fr == 1 && !mem_valid);
    endfunction

    function automatic void m_fwd(output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_FWD_EN
        if (fwd_addr != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].rd == fwd_addr) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
            if (!hit && m_rw && m_wreg == fwd_addr) begin
                hit = 1'b1;
                d   = m_wdata;
            end
        end
`endif
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_rw    = 1'b0;
            m_wreg  = '0;
            m_wdata = '0;
        end else begin
            acc_m = mem_valid && exp_mem_ready();
            acc_a = alu_valid && exp_alu_ready();
            if (mq.size() > 0 && !wb_stall) begin
                e_tmp   = mq.pop_front();
                m_rw    = 1'b1;
                m_wreg  = e_tmp.rd;
                m_wdata = e_tmp.data;
            end else begin
                m_rw = 1'b0;
            end
            if (acc_m && mem_rd != '0) begin
                e_tmp.rd = mem_rd; e_tmp.data = mem_data; mq.push_back(e_tmp);
            end
            if (acc_a && alu_rd != '0) begin
                e_tmp.rd = alu_rd; e_tmp.data = alu_data; mq.push_back(e_tmp);
            end
        end
    end

    always @(negedge clock) begin
        m_fwd(f_hit, f_data);
        check("cmp_count",     32'(count),     32'(mq.size()));
        check("cmp_mem_ready", 32'(mem_ready), 32'(exp_mem_ready()));
        check("cmp_alu_ready", 32'(alu_ready), 32'(exp_alu_ready()));
        check("cmp_regWrite",  32'(regWrite),  32'(m_rw));
        check("cmp_writeReg",  32'(writeReg),  32'(m_wreg));
        check("cmp_writeData", writeData,      m_wdata);
        check("cmp_fwd_hit",   32'(fwd_hit),   32'(f_hit));
        check("cmp_fwd_data",  fwd_data,       f_data);
        if (regWrite) seen.push_back(writeData);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0; wb_stall = 1'b0; fwd_addr = '0;
        step(); step();
        reset = 1'b1;
        step();

        // Reset while mid-drain with three entries left.
        wb_stall = 1'b1;
        alu_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            alu_rd = ADDR_W'(k); alu_data = 32'h100 + 32'(k);
            step();
        end
        alu_valid = 1'b0; wb_stall = 1'b0;
        step(); #1;
        check("rst_pre_count", 32'(count), 32'd3);
        check("rst_pre_strobe", 32'(regWrite), 32'd1);
        reset = 1'b0; #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_writeReg", 32'(writeReg), 32'd0);
        check("rst_writeData", writeData, 32'd0);
        step(); reset = 1'b1;
        step(); step(); #1;
        check("rst_post_regWrite", 32'(regWrite), 32'd0);
        check("rst_post_count", 32'(count), 32'd0);

        // Single ALU push and its two-edge latency.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        step(); alu_valid = 1'b0; #1;
        check("single_count1", 32'(count), 32'd1);
        check("single_no_strobe_yet", 32'(regWrite), 32'd0);
        step(); #1;
        check("single_strobe", 32'(regWrite), 32'd1);
        check("single_writeReg", 32'(writeReg), 32'd5);
        check("single_writeData", writeData, 32'hDEADBEEF);
        check("single_count0", 32'(count), 32'd0);
        step(); #1;
        check("single_strobe_off", 32'(regWrite), 32'd0);
        check("single_hold_reg", 32'(writeReg), 32'd5);

        // Simultaneous mem/alu to the same register: mem is older.
        seen.delete();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22; fwd_addr = 5'd3; #1;
        check("dual_mem_ready", 32'(mem_ready), 32'd1);
        check("dual_alu_ready", 32'(alu_ready), 32'd1);
        step(); mem_valid = 1'b0; alu_valid = 1'b0; #1;
        check("dual_count", 32'(count), 32'd2);
`ifdef WB_FWD_EN
        check("dual_fwd_hit", 32'(fwd_hit), 32'd1);
        check("dual_fwd_data", fwd_data, 32'h22);
`else
        check("dual_fwd_hit", 32'(fwd_hit), 32'd0);
        check("dual_fwd_data", fwd_data, 32'd0);
`endif
        step(); step(); step();
        check("dual_nwrites", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("dual_first", seen[0], 32'h11);
            check("dual_second", seen[1], 32'h22);
        end

        // Fill under stall, mem wins the last slot, then drain across the pointer wrap.
        fwd_addr = '0; wb_stall = 1'b1; alu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_rd = ADDR_W'(10 + k); alu_data = 32'hA0 + 32'(k);
            step();
        end
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hA3;
        alu_rd = 5'd14; alu_data = 32'hA4; #1;
        check("full_pre_count", 32'(count), 32'd3);
        check("full_mem_ready", 32'(mem_ready), 32'd1);
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        step(); mem_valid = 1'b0; #1;
        check("full_count", 32'(count), 32'd4);
        check("full_mem_ready0", 32'(mem_ready), 32'd0);
        check("full_alu_ready0", 32'(alu_ready), 32'd0);
        step(); #1;
        check("full_frozen", 32'(count), 32'd4);
        alu_valid = 1'b0; seen.delete(); wb_stall = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("full_nwrites", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            for (int k = 0; k < 4; k++) check("full_order", seen[k], 32'hA0 + 32'(k));
        end

        // x0 results complete the handshake but vanish.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55; fwd_addr = 5'd0; #1;
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        check("x0_fwd_hit", 32'(fwd_hit), 32'd0);
        step(); alu_valid = 1'b0; #1;
        check("x0_count", 32'(count), 32'd0);
        step(); #1;
        check("x0_no_strobe", 32'(regWrite), 32'd0);

        // Pending rd=7 seen (or not) by the forwarding path.
        wb_stall = 1'b1; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77; fwd_addr = 5'd7;
        step(); alu_valid = 1'b0; #1;
        check("fwd7_count", 32'(count), 32'd1);
`ifdef WB_FWD_EN
        check("fwd7_hit", 32'(fwd_hit), 32'd1);
        check("fwd7_data", fwd_data, 32'h77);
`else
        check("fwd7_hit", 32'(fwd_hit), 32'd0);
        check("fwd7_data", fwd_data, 32'd0);
`endif
        wb_stall = 1'b0;
        step(); step();

        // Mixed traffic pattern checked by the model alone.
        for (int i = 0; i < 48; i++) begin
            mem_valid = (i % 3) != 0;
            mem_rd    = ADDR_W'(i % 4);
            mem_data  = 32'h1000 + 32'(i);
            alu_valid = (i % 2) == 0 || (i % 5) == 1;
            alu_rd    = ADDR_W'((i * 3) % 5);
            alu_data  = 32'h2000 + 32'(i);
            wb_stall  = (i % 7) >= 4;
            fwd_addr  = ADDR_W'(i % 5);
            step();
        end
        mem_valid = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("final_empty", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back sequencer that sits on the write side of the register file (regs).
- Accepts results from two producers, the ALU path and the memory/load path.
- Buffers them in an in-order FIFO and drains them one per cycle into the register file's single write port (regWrite/writeReg/writeData).
- Can forward not-yet-retired values to the decode-side read path.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 5, register index width
DATA_W, 32, data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result offered
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this edge
mem_valid  in  1  load result offered
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load result accepted this edge
wb_stall  in  1  inhibit draining
regWrite  out  1  write strobe to register file
writeReg  out  ADDR_W  write index to register file
writeData  out  DATA_W  write data to register file
count  out  clog2(DEPTH)+1  occupied FIFO entries
fwd_addr  in  ADDR_W  register being read by decode
fwd_hit  out  1  pending write to fwd_addr exists
fwd_data  out  DATA_W  newest pending value for fwd_addr

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, regWrite=0, writeReg=0, writeData=0. Release is synchronous to clock. Any entry in flight is discarded.
- Handshake: a transfer occurs on a rising edge where valid&ready=1. Producers hold rd/data stable while valid&!ready.
- Ready rules:
  - mem_ready = (free>=1), where free = DEPTH-count.
  - alu_ready = (free>=2) | (free==1 & !mem_valid).
  - Memory has priority when exactly one slot is free.
  - Ready depends only on registered count, never on a same-cycle pop (no fall-through).
- Enqueue order: if both transfer on the same edge, the mem entry is written first (older), then the alu entry.
- x0 filtering: a transfer with rd==0 completes the handshake but is not enqueued and not counted.
- Drain: on each edge with count>0 & !wb_stall, the head is popped into the output registers and regWrite=1 for exactly the following cycle. Otherwise regWrite=0 next cycle; writeReg/writeData hold their last values.
- Latency: an entry enqueued at edge N into an empty queue drives regWrite in the cycle after edge N+1. The register file captures it at edge N+2.
- Throughput: one retirement per cycle. Push and pop on the same edge are allowed: count += pushes - pops.
- Full: count==DEPTH, so mem_ready=alu_ready=0. Empty: no strobe.
- Pointers are DEPTH-modulo; wrap-around must not reorder entries.
- wb_stall while full: no accept, no drain, state frozen.
- Forwarding search (combinational):
  - Sources are the FIFO entries and the output stage while regWrite=1.
  - The youngest match wins; the FIFO is younger than the output stage.
  - fwd_addr==0 gives fwd_hit=0, fwd_data=0.
  - No match gives fwd_hit=0, fwd_data=0.
- count is registered.

Optional Feature:
WB_FWD_EN
- Defined: forwarding search is implemented as above.
- Undefined: the fwd_addr input is ignored, fwd_hit is tied to 0, fwd_data is tied to 0, and no search logic is generated. The read path must then stall on count!=0.

Test Plan:
- Reset with the queue holding 3 entries (reset=0 mid-drain) -> immediately count=0, regWrite=0, writeReg=0, writeData=0. No strobe after release until a new push.
- Single alu push rd=5 data=0xDEADBEEF at edge N -> regWrite=1, writeReg=5, writeData=0xDEADBEEF only in the cycle after edge N+1. count goes 1 then 0.
- Simultaneous mem(rd=3,0x11) and alu(rd=3,0x22) with empty queue -> both accepted. Writes occur in order 0x11 then 0x22. With WB_FWD_EN, fwd_addr=3 returns 0x22 while pending.
- Fill to DEPTH-1=3 with wb_stall=1, then offer mem and alu together -> mem_ready=1, alu_ready=0. count=4, then both readies=0. Release stall -> 4 strobes on consecutive cycles, in FIFO order, across pointer wrap.
- alu push rd=0 data=0x55 -> alu_ready=1 and handshake completes, count stays 0, no regWrite. fwd_addr=0 gives fwd_hit=0.
- Without WB_FWD_EN: pending rd=7 entry, fwd_addr=7 -> fwd_hit=0, fwd_data=0.
